uart_txd: RTL and testbench
===========================

UART_TXD -- requirements
Module: uart_txd

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416, meaning 100 MHz clocks per bit at 9600 baud.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning byte-buffer entries (power of two, 2 to 64).
REQ-003 SHALL have port clk  input  1  single system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cipher_done  input  1  one-clock strobe: data_from_cipher is valid.
REQ-006 SHALL have port data_from_cipher  input  8  byte to transmit.
REQ-007 SHALL have port txd_data_out  output  1  serial line; idle high.
REQ-008 SHALL have port txd_busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-009 SHALL have port fifo_full  output  1  high when FIFO holds FIFO_DEPTH bytes.
REQ-010 SHALL have port overflow  output  1  sticky; set when a byte is dropped.

Function
REQ-011 SHALL frame each byte as 8N1: start bit 0, eight data bits LSB first, stop bit 1.
REQ-012 SHALL hold each bit on txd_data_out for exactly CLKS_PER_BIT clocks.
REQ-013 SHALL write data_from_cipher into the FIFO on a cipher_done clock when not full.
REQ-014 SHALL drop the byte and set overflow on a cipher_done clock when full; FIFO contents SHALL be unchanged.
REQ-015 SHALL accept a write on the same clock as a pop when the FIFO is full; occupancy SHALL be unchanged and overflow SHALL not set.
REQ-016 SHALL use states IDLE, START, DATA and STOP.
REQ-017 SHALL move from IDLE to START on the clock after the FIFO becomes non-empty, popping the head byte into a shift register on that transition.
REQ-018 SHALL make the latency from cipher_done into an empty idle block to the falling edge of txd_data_out exactly 2 clocks.
REQ-019 SHALL go START to DATA after one bit time.
REQ-020 SHALL go DATA to STOP after 8 bit times, with a 3-bit bit index that wraps 7 to 0.
REQ-021 SHALL go STOP to START immediately when the FIFO is non-empty at the end of the stop bit (back-to-back frames, no idle gap); otherwise STOP goes to IDLE.
REQ-022 SHALL reset the baud counter to 0 on every state transition and SHALL count 0 to CLKS_PER_BIT-1.
REQ-023 SHALL size the baud counter at clog2(CLKS_PER_BIT) bits.
REQ-024 SHALL derive fifo_full and empty from read/write pointers one bit wider than clog2(FIFO_DEPTH); pointers SHALL wrap modulo 2*FIFO_DEPTH.
REQ-025 SHALL drive txd_data_out from a register, glitch-free.
REQ-026 SHALL deassert txd_busy on the first clock in IDLE with the FIFO empty.

Reset
REQ-027 SHALL, while rst is low, force: state IDLE; txd_data_out 1; txd_busy 0; fifo_full 0; overflow 0; pointers, baud counter and bit index 0.
REQ-028 SHALL abandon any frame in progress on reset assertion mid-frame, with the line high immediately, asynchronously.
REQ-029 SHALL discard all FIFO contents on reset.
REQ-030 SHALL clear overflow only by reset.

Structure
REQ-031 SHALL place state encodings (IDLE=0, START=1, DATA=2, STOP=3) and default CLKS_PER_BIT in a shared package uart_pkg, also used by uart_rxd.
REQ-032 SHALL implement the byte buffer as sub-module uart_tx_fifo: synchronous write, show-ahead read, full/empty flags.
REQ-033 SHALL keep the transmit FSM and baud counter in uart_txd.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-034 SHALL cover: single 0xA5 after reset -> line low 2 clocks after strobe; bits 1,0,1,0,0,1,0,1 at 16 clocks each; stop high; txd_busy low after 160 clocks.
REQ-035 SHALL cover: 0x00 then 0xFF strobed on consecutive clocks -> two frames back-to-back, second start bit directly follows first stop bit, 320 clocks total.
REQ-036 SHALL cover: 6 strobes 0x01..0x06 in 6 clocks while idle -> 0x01 popped; 0x02..0x05 fill FIFO; 0x06 dropped; overflow=1; line carries 0x01..0x05 only.
REQ-037 SHALL cover: with FIFO full, strobe 0x77 on the pop clock -> 0x77 accepted; overflow stays 0.
REQ-038 SHALL cover: rst low mid-DATA of 0x3C -> txd_data_out=1 at once; after release nothing is transmitted; txd_busy=0.
REQ-039 SHALL cover: 2*FIFO_DEPTH+1 frames of incrementing bytes -> pointer wrap; every byte received in order by a uart_rxd model.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the transmitter (uart_txd) and the
// receiver (uart_rxd): FSM state encodings and the default bit period.
// No ports; compile before any module that imports it.
// ----------------------------------------------------------------------------
package uart_pkg;

    // Line-state encodings are fixed so both directions decode the same values.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // 100 MHz system clock divided down to 9600 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 10416;

endpackage

// File: rtl/uart_txd_if.sv
// ----------------------------------------------------------------------------
// uart_txd_if
// Byte hand-off from the cipher to the UART transmitter.
//   cipher_done       : one-clock strobe, data_from_cipher is valid
//   data_from_cipher  : byte to transmit
// Modports: master = cipher side (drives), slave = transmitter side (samples).
// ----------------------------------------------------------------------------
interface uart_txd_if;

    logic       cipher_done;
    logic [7:0] data_from_cipher;

    modport master (output cipher_done, output data_from_cipher);
    modport slave  (input  cipher_done, input  data_from_cipher);

endinterface

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
// Byte buffer in front of the transmitter. Synchronous write, show-ahead
// read (rd_data_o is the head byte whenever empty_o is low).
// Ports:
//   clk, rst            : system clock, asynchronous active-low reset
//   wr_en_i, wr_data_i  : push request and byte
//   rd_en_i             : pop the head byte
//   rd_data_o           : head byte
//   full_o, empty_o     : occupancy flags
// A push while full is accepted only if a pop happens on the same clock;
// the freed slot is the one being written, so occupancy stays the same.
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en_i,
    input  logic [7:0] wr_data_i,
    input  logic       rd_en_i,
    output logic [7:0] rd_data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;     // extra wrap bit tells full from empty

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          full_s, empty_s, rd_ok_s, wr_ok_s;

    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_ok_s = rd_en_i && !empty_s;
    assign wr_ok_s = wr_en_i && (!full_s || rd_ok_s);

    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign full_o    = full_s;
    assign empty_o   = empty_s;

    // Pointer next-state; pointers wrap naturally modulo 2*DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_ok_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers; reset empties the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_txd.sv
// ----------------------------------------------------------------------------
// uart_txd
// Buffered 8N1 UART transmitter. Bytes strobed in from the cipher are queued
// in uart_tx_fifo and shifted out LSB first, one bit per CLKS_PER_BIT clocks.
// Ports:
//   clk           : system clock, rising edge
//   rst           : asynchronous active-low reset
//   cif           : uart_txd_if.slave (cipher_done strobe + data_from_cipher)
//   txd_data_out  : serial line, idle high, registered
//   txd_busy      : frame on the line or bytes waiting
//   fifo_full     : buffer holds FIFO_DEPTH bytes
//   overflow      : sticky, a byte was dropped; cleared only by reset
// ----------------------------------------------------------------------------
module uart_txd
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst,
    uart_txd_if.slave  cif,
    output logic       txd_data_out,
    output logic       txd_busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    uart_state_e   state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;

    logic          pop_s, bit_end_s, wr_acc_s;
    logic          fifo_full_s, fifo_empty_s;
    logic [7:0]    fifo_head_s;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (cif.cipher_done),
        .wr_data_i (cif.data_from_cipher),
        .rd_en_i   (pop_s),
        .rd_data_o (fifo_head_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s)
    );

    assign bit_end_s = (baud_q == CW'(CLKS_PER_BIT - 1));
    // A full buffer still takes a byte when the FSM pops on the same clock.
    assign wr_acc_s  = cif.cipher_done && (!fifo_full_s || pop_s);

    // Transmit FSM: next state, baud/bit counters and the next line level.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + CW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        pop_s     = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty_s) begin
                    state_d = START;
                    pop_s   = 1'b1;
                    shift_d = fifo_head_s;
                    txd_d   = 1'b0;
                end else begin
                    txd_d   = 1'b1;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_d   = DATA;
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    txd_d     = shift_q[0];
                end else begin
                    txd_d     = 1'b0;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    baud_d    = '0;
                    bit_idx_d = bit_idx_q + 3'd1;   // 7 wraps back to 0
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        // Shift right so the next data bit sits at [0].
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end else begin
                    txd_d = txd_q;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    baud_d = '0;
                    if (!fifo_empty_s) begin
                        state_d = START;            // back-to-back frame
                        pop_s   = 1'b1;
                        shift_d = fifo_head_s;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    txd_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                txd_d   = 1'b1;
            end
        endcase
    end

    // Status: busy follows the state being entered plus any byte just queued.
    always_comb begin
        busy_d = (state_d != IDLE) || wr_acc_s;
        ovf_d  = ovf_q || (cif.cipher_done && fifo_full_s && !pop_s);
    end

    // State and datapath registers; reset drives the line high at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    assign txd_data_out = txd_q;
    assign txd_busy     = busy_q;
    assign fifo_full    = fifo_full_s;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_uart_txd.sv
// ----------------------------------------------------------------------------
// tb_uart_txd
// Directed bench for uart_txd with CLKS_PER_BIT=16, FIFO_DEPTH=4.
// A small serial receiver model decodes every frame on the line into rx_q.
// ----------------------------------------------------------------------------
module tb_uart_txd;

    localparam int CPB = 16;
    localparam int FRAME = 10 * CPB;

    logic clk;
    logic rst;
    logic txd_data_out, txd_busy, fifo_full, overflow;

    int chk_cnt = 0;
    int err_cnt = 0;

    logic       rx_en;
    logic [7:0] rx_byte;
    logic [7:0] rx_q [$];

    uart_txd_if cif ();

    uart_txd #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cif          (cif),
        .txd_data_out (txd_data_out),
        .txd_busy     (txd_busy),
        .fifo_full    (fifo_full),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b);
        cif.cipher_done      = 1'b1;
        cif.data_from_cipher = b;
    endtask

    task automatic unstrobe();
        cif.cipher_done      = 1'b0;
        cif.data_from_cipher = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rx_q.delete();
        tick();
    endtask

    // Called at the first clock the start bit is on the line; checks the
    // first and last clock of every bit, ending one frame time later.
    task automatic expect_frame(input logic [7:0] b, input string tag);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < FRAME; k++) begin
            if ((k % CPB) == 0 || (k % CPB) == CPB - 1)
                check_val($sformatf("%s_bit%0d_k%0d", tag, k / CPB, k), {31'd0, txd_data_out}, {31'd0, fr[k / CPB]});
            tick();
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (txd_busy !== 1'b0 && n < 3000) begin
            tick();
            n++;
        end
        check_val(tag, {31'd0, (n < 3000)}, 32'd1);
    endtask

    // Serial receiver model: samples mid-bit after each falling start edge.
    initial begin
        forever begin
            @(negedge txd_data_out);
            if (rx_en) begin
                repeat (CPB / 2) @(posedge clk);
                #1;
                check_val("rx_start", {31'd0, txd_data_out}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clk);
                    #1;
                    rx_byte[i] = txd_data_out;
                end
                repeat (CPB) @(posedge clk);
                #1;
                check_val("rx_stop", {31'd0, txd_data_out}, 32'd1);
                rx_q.push_back(rx_byte);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_low;
        int   n;
        rx_en = 1'b1;
        rst   = 1'b0;
        unstrobe();

        // Reset state
        #12;
        check_val("rst_txd",  {31'd0, txd_data_out}, 32'd1);
        check_val("rst_busy", {31'd0, txd_busy},     32'd0);
        check_val("rst_full", {31'd0, fifo_full},    32'd0);
        check_val("rst_ovf",  {31'd0, overflow},     32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Single 0xA5: line falls two clocks after the strobe
        strobe(8'hA5);
        tick();
        unstrobe();
        check_val("a5_not_early", {31'd0, txd_data_out}, 32'd1);
        check_val("a5_busy_q",    {31'd0, txd_busy},     32'd1);
        tick();
        expect_frame(8'hA5, "a5");
        check_val("a5_busy_160", {31'd0, txd_busy},     32'd0);
        check_val("a5_idle_txd", {31'd0, txd_data_out}, 32'd1);
        check_val("a5_rx_n",     rx_q.size(),           32'd1);
        if (rx_q.size() > 0) check_val("a5_rx", {24'd0, rx_q[0]}, 32'hA5);
        rx_q.delete();

        // 0x00 then 0xFF on consecutive clocks: back-to-back frames
        strobe(8'h00);
        tick();
        strobe(8'hFF);
        tick();
        unstrobe();
        expect_frame(8'h00, "b2b0");
        expect_frame(8'hFF, "b2b1");
        check_val("b2b_busy_320", {31'd0, txd_busy}, 32'd0);

        // Six strobes while idle: 0x01 popped, 0x02..0x05 fill, 0x06 dropped
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            strobe(8'(i));
            tick();
        end
        unstrobe();
        check_val("ovf_set",  {31'd0, overflow},  32'd1);
        check_val("ovf_full", {31'd0, fifo_full}, 32'd1);
        wait_idle("ovf_wait");
        check_val("ovf_sticky", {31'd0, overflow}, 32'd1);
        check_val("ovf_rx_n",   rx_q.size(),       32'd5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            check_val($sformatf("ovf_rx%0d", i), {24'd0, rx_q[i]}, 32'(i + 1));

        // Write on the pop clock while full: accepted, no overflow
        do_reset();
        for (int i = 0; i < 5; i++) begin
            strobe(8'h10 + 8'(i));
            tick();
        end
        unstrobe();
        check_val("pop_full_pre", {31'd0, fifo_full}, 32'd1);
        repeat (FRAME - 4) tick();
        strobe(8'h77);
        tick();
        unstrobe();
        check_val("pop_full_post", {31'd0, fifo_full},    32'd1);
        check_val("pop_ovf",       {31'd0, overflow},     32'd0);
        check_val("pop_start",     {31'd0, txd_data_out}, 32'd0);
        wait_idle("pop_wait");
        check_val("pop_ovf_end", {31'd0, overflow}, 32'd0);
        check_val("pop_rx_n",    rx_q.size(),       32'd6);
        for (int i = 0; i < 6 && i < rx_q.size(); i++)
            check_val($sformatf("pop_rx%0d", i), {24'd0, rx_q[i]}, (i < 5) ? 32'h10 + 32'(i) : 32'h77);

        // Reset mid-DATA of 0x3C with 0x55 still queued
        do_reset();
        rx_en = 1'b0;
        strobe(8'h3C);
        tick();
        strobe(8'h55);
        tick();
        unstrobe();
        repeat (CPB + 4) tick();
        check_val("rst_mid_pre", {31'd0, txd_data_out}, 32'd0);
        #3 rst = 1'b0;
        #1;
        check_val("rst_mid_txd",  {31'd0, txd_data_out}, 32'd1);
        check_val("rst_mid_busy", {31'd0, txd_busy},     32'd0);
        check_val("rst_mid_full", {31'd0, fifo_full},    32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        seen_low = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (txd_data_out !== 1'b1 || txd_busy !== 1'b0) seen_low = 1'b1;
        end
        check_val("rst_quiet", {31'd0, seen_low}, 32'd0);
        rx_en = 1'b1;

        // 2*DEPTH+1 frames: pointer wrap, order preserved
        do_reset();
        for (int i = 0; i < 9; i++) begin
            n = 0;
            while (fifo_full === 1'b1 && n < 3000) begin
                tick();
                n++;
            end
            check_val($sformatf("wrap_space%0d", i), {31'd0, (n < 3000)}, 32'd1);
            strobe(8'h40 + 8'(i));
            tick();
            unstrobe();
        end
        wait_idle("wrap_wait");
        check_val("wrap_ovf",  {31'd0, overflow}, 32'd0);
        check_val("wrap_rx_n", rx_q.size(),       32'd9);
        for (int i = 0; i < 9 && i < rx_q.size(); i++)
            check_val($sformatf("wrap_rx%0d", i), {24'd0, rx_q[i]}, 32'h40 + 32'(i));

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
